// File: rtl/int_ctrl_pkg.sv
// Shared types and sizing for the int_ctrl interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ASSERT  = 2'b01,
        SERVICE = 2'b10
    } state_e;

    // Priority encoder result: valid flag plus winning index.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] idx;
    } prio_t;

endpackage

// File: rtl/int_ctrl_prio_enc4.sv
// Combinational 4-input priority encoder; bit 0 has the highest priority.
module prio_enc4
    import int_ctrl_pkg::*;
(
    input  logic [3:0] eligible,
    output prio_t      res
);

    always_comb begin
        res = '0;
        if (eligible[0]) begin
            res.valid = 1'b1;
            res.idx   = 2'd0;
        end else if (eligible[1]) begin
            res.valid = 1'b1;
            res.idx   = 2'd1;
        end else if (eligible[2]) begin
            res.valid = 1'b1;
            res.idx   = 2'd2;
        end else if (eligible[3]) begin
            res.valid = 1'b1;
            res.idx   = 2'd3;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with a
// non-nesting IDLE/ASSERT/SERVICE handshake towards the CPU.
module int_ctrl #(
    parameter int unsigned N_SRC = int_ctrl_pkg::N_SRC,
    parameter int unsigned ID_W  = int_ctrl_pkg::ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             ack,
    input  logic             eoi,
    output logic             INT,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending,
    output logic             busy
);
    import int_ctrl_pkg::*;

    state_e           state;
    state_e           state_nxt;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_nxt;
    logic [ID_W-1:0]  id_nxt;
    prio_t            prio;

    prio_enc4 u_prio (
        .eligible (pending & mask),
        .res      (prio)
    );

    // Pending bookkeeping: a new edge beats a same-cycle acknowledge clear.
    always_comb begin
        rise = irq & ~irq_q;
        clr  = '0;
        if (state == ASSERT && ack) begin
            clr[int_id] = 1'b1;
        end
        pending_nxt = (pending & ~clr) | rise;
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = int_id;
        case (state)
            IDLE: begin
                if (prio.valid) begin
                    state_nxt = ASSERT;
                    id_nxt    = prio.idx;
                end
            end
            ASSERT: begin
                if (ack) begin
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // INT and busy are flopped copies of the next-state decode, so they track state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            irq_q   <= '0;
            mask    <= '1;
            pending <= '0;
            int_id  <= '0;
            INT     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq;
            pending <= pending_nxt;
            int_id  <= id_nxt;
            INT     <= (state_nxt == ASSERT);
            busy    <= (state_nxt == SERVICE);
            if (mask_wr) begin
                mask <= mask_din;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scenarios plus randomized traffic against a flag-based behavioural model.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] irq = '0;
    logic       mask_wr = 1'b0;
    logic [3:0] mask_din = '0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       INT;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: request raised, being serviced, chosen source.
    logic [3:0] m_pending = '0;
    logic [3:0] m_mask    = 4'hF;
    logic [3:0] m_prev    = '0;
    logic [1:0] m_id      = '0;
    bit         m_int     = 1'b0;
    bit         m_busy    = 1'b0;

    int_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .ack      (ack),
        .eoi      (eoi),
        .INT      (INT),
        .int_id   (int_id),
        .pending  (pending),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [3:0] rise;
        logic [3:0] elig;
        logic [3:0] nxt;
        bit         found;
        if (rst) begin
            m_pending = '0;
            m_prev    = '0;
            m_mask    = 4'hF;
            m_id      = '0;
            m_int     = 1'b0;
            m_busy    = 1'b0;
        end else begin
            rise = irq & ~m_prev;
            elig = m_pending & m_mask;
            nxt  = m_pending;
            if (m_int && ack) nxt[m_id] = 1'b0;
            nxt = nxt | rise;
            if (!m_int && !m_busy) begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && elig[i]) begin
                        found = 1'b1;
                        m_id  = 2'(i);
                        m_int = 1'b1;
                    end
                end
            end else if (m_int) begin
                if (ack) begin
                    m_int  = 1'b0;
                    m_busy = 1'b1;
                end
            end else if (eoi) begin
                m_busy = 1'b0;
            end
            if (mask_wr) m_mask = mask_din;
            m_pending = nxt;
            m_prev    = irq;
        end
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later,
    // then one-cycle pulses are dropped on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("INT", 32'(INT), 32'(m_int));
        check("busy", 32'(busy), 32'(m_busy));
        check("int_id", 32'(int_id), 32'(m_id));
        check("pending", 32'(pending), 32'(m_pending));
        @(negedge clk);
        ack     = 1'b0;
        eoi     = 1'b0;
        mask_wr = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("reset_int", 32'(INT), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);

        // Single request on source 2, full handshake.
        irq = 4'b0100; tick();
        check("r36_pend", 32'(pending), 32'h4);
        check("r36_int_early", 32'(INT), 32'd0);
        irq = 4'b0000; tick();
        check("r36_int", 32'(INT), 32'd1);
        check("r36_id", 32'(int_id), 32'd2);
        ack = 1'b1; tick();
        check("r36_busy", 32'(busy), 32'd1);
        check("r36_clr", 32'(pending), 32'd0);
        eoi = 1'b1; tick();
        check("r36_idle", 32'(INT | busy), 32'd0);

        // Simultaneous edges on 1 and 3: 1 first, then 3 after one idle cycle.
        irq = 4'b1010; tick();
        irq = 4'b0000; tick();
        check("r37_first", 32'(int_id), 32'd1);
        ack = 1'b1; tick();
        eoi = 1'b1; tick();
        check("r37_gap", 32'(INT), 32'd0);
        tick();
        check("r37_second_int", 32'(INT), 32'd1);
        check("r37_second_id", 32'(int_id), 32'd3);
        ack = 1'b1; tick();
        eoi = 1'b1; tick();

        // Masked source stays latched until unmasked.
        mask_wr = 1'b1; mask_din = 4'b1110; irq = 4'b0001; tick();
        irq = 4'b0000; tick();
        check("r38_pend", 32'(pending), 32'h1);
        check("r38_masked", 32'(INT), 32'd0);
        mask_wr = 1'b1; mask_din = 4'b1111; tick();
        check("r38_wait", 32'(INT), 32'd0);
        tick();
        check("r38_int", 32'(INT), 32'd1);
        check("r38_id", 32'(int_id), 32'd0);
        ack = 1'b1; tick();
        eoi = 1'b1; tick();

        // Ack racing a fresh edge on the same source: the set wins.
        irq = 4'b0100; tick();
        irq = 4'b0000; tick();
        irq = 4'b0100; ack = 1'b1; tick();
        check("r39_busy", 32'(busy), 32'd1);
        check("r39_keep", 32'(pending[2]), 32'd1);
        irq = 4'b0000; eoi = 1'b1; tick();
        tick();
        check("r39_reassert", 32'(INT), 32'd1);
        check("r39_id", 32'(int_id), 32'd2);
        ack = 1'b1; tick();
        eoi = 1'b1; tick();

        // Reset mid-SERVICE, then stray handshakes.
        irq = 4'b0010; tick();
        irq = 4'b0000; tick();
        ack = 1'b1; tick();
        irq = 4'b0110; tick();
        check("r40_pend", 32'(pending), 32'h6);
        irq = 4'b0000; rst = 1'b1; tick();
        check("r40_rst", 32'({INT, busy, int_id, pending}), 32'd0);
        ack = 1'b1; tick();
        eoi = 1'b1; tick();
        check("r40_stray", 32'({INT, busy, pending}), 32'd0);

        // Level held across reset release is seen as an edge afterwards.
        irq = 4'b1000; rst = 1'b1; tick();
        tick();
        check("r32_edge", 32'(pending), 32'h8);
        tick();
        check("r32_int", 32'(int_id), 32'd3);
        irq = 4'b0000;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom);
            ack      = ($urandom_range(0, 2) == 0);
            eoi      = ($urandom_range(0, 2) == 0);
            mask_wr  = ($urandom_range(0, 9) == 0);
            mask_din = 4'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
